// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit pipeline: IF/ID field layout, FSM encoding and program ROM image.
// The fetch unit's optional branch redirect is enabled with IFU_BRANCH_EN.
package pipe_pkg;

   localparam int INSTR_W  = 8;
   localparam int FUNC_W   = 2;
   localparam int RDST_W   = 3;
   localparam int RSRC_W   = 3;
   localparam int RSRC_LSB = 0;
   localparam int RDST_LSB = RSRC_LSB + RSRC_W;
   localparam int FUNC_LSB = RDST_LSB + RDST_W;

   localparam logic [INSTR_W-1:0] HALT_INSTR = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } ifu_state_t;

   // Element 0 is the rightmost entry; anything past PROG_DEPTH reads as zero.
   localparam int PROG_DEPTH = 16;
   localparam logic [PROG_DEPTH-1:0][INSTR_W-1:0] PROG_ROM =
      {{12{8'h00}}, 8'hFF, 8'hD3, 8'h91, 8'h4A};

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Control and IF/ID bus between the pipeline controller (master) and the fetch unit (slave).
interface instr_fetch_unit_if
   import pipe_pkg::*;
#(
   parameter int ADDR_W = 4
) ();

   logic               start;
   logic               stall;
   logic               branch_en;
   logic [ADDR_W-1:0]  branch_target;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  pc_out;
   logic               fetch_valid;
   logic               halted;

   modport master (
      output start, stall, branch_en, branch_target,
      input  instr, pc_out, fetch_valid, halted
   );

   modport slave (
      input  start, stall, branch_en, branch_target,
      output instr, pc_out, fetch_valid, halted
   );

endinterface

// File: rtl/instr_rom.sv
// Combinational instruction ROM backed by the PROG_ROM image.
// NO_HALT_ROM replaces HALT words with zero, giving a program that runs forever.
module instr_rom
   import pipe_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter bit NO_HALT_ROM = 1'b0
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic [INSTR_W-1:0] data
);

   logic [31:0] idx;

   always_comb begin
      idx  = 32'(addr);
      data = '0;
      if (idx < 32'(PROG_DEPTH)) begin
         data = PROG_ROM[idx[3:0]];
      end
      if (NO_HALT_ROM && (data == HALT_INSTR)) begin
         data = '0;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, IDLE/RUN/HALT control and registered IF/ID outputs.
// Define IFU_BRANCH_EN to honour branch_en/branch_target (redirect plus one bubble).
module instr_fetch_unit
   import pipe_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter bit NO_HALT_ROM = 1'b0
) (
   input logic               clk,
   input logic               reset,
   instr_fetch_unit_if.slave bus
);

   ifu_state_t         state, state_n;
   logic [ADDR_W-1:0]  pc, pc_n;
   logic [INSTR_W-1:0] instr_q, instr_n;
   logic [ADDR_W-1:0]  pc_out_q, pc_out_n;
   logic               valid_q, valid_n;
   logic               halted_q, halted_n;
   logic [INSTR_W-1:0] rom_data;

   instr_rom #(
      .ADDR_W      (ADDR_W),
      .NO_HALT_ROM (NO_HALT_ROM)
   ) u_rom (
      .addr (pc),
      .data (rom_data)
   );

`ifndef IFU_BRANCH_EN
   logic unused_branch;
   assign unused_branch = ^{bus.branch_en, bus.branch_target};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= '0;
         instr_q  <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         instr_q  <= instr_n;
         pc_out_q <= pc_out_n;
         valid_q  <= valid_n;
         halted_q <= halted_n;
      end
   end

   // Branch outranks stall; the HALT word is issued like any other, and HALT clears the outputs.
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      instr_n  = instr_q;
      pc_out_n = pc_out_q;
      valid_n  = valid_q;
      halted_n = halted_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = RUN;
               pc_n    = '0;
            end
         end
         RUN: begin
`ifdef IFU_BRANCH_EN
            if (bus.branch_en) begin
               pc_n    = bus.branch_target;
               instr_n = '0;
               valid_n = 1'b0;
            end else
`endif
            if (!bus.stall) begin
               instr_n  = rom_data;
               pc_out_n = pc;
               valid_n  = 1'b1;
               pc_n     = pc + ADDR_W'(1);
               if (rom_data == HALT_INSTR) begin
                  state_n = HALT;
               end
            end
         end
         HALT: begin
            instr_n = '0;
            valid_n = 1'b0;
            if (bus.start) begin
               state_n  = RUN;
               pc_n     = '0;
               halted_n = 1'b0;
            end else begin
               halted_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.instr       = instr_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.fetch_valid = valid_q;
   assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program run, stall, async reset, restart, branch, PC wrap.
// Branch expectations follow IFU_BRANCH_EN, matching the build of the design.
module tb_instr_fetch_unit;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;

   instr_fetch_unit_if #(.ADDR_W(4)) bus ();
   instr_fetch_unit_if #(.ADDR_W(4)) bus2 ();

   instr_fetch_unit #(.ADDR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   instr_fetch_unit #(.ADDR_W(4), .NO_HALT_ROM(1'b1)) dut_nohalt (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic st, input logic be, input logic [3:0] bt);
      bus.start         = s;
      bus.stall         = st;
      bus.branch_en     = be;
      bus.branch_target = bt;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkFetch(input string tag, input logic [7:0] ins, input logic [3:0] pc, input logic v);
      checkOutput({tag, " instr"}, 32'(bus.instr), 32'(ins));
      checkOutput({tag, " pc_out"}, 32'(bus.pc_out), 32'(pc));
      checkOutput({tag, " valid"}, 32'(bus.fetch_valid), 32'(v));
   endtask

   logic [7:0] nohalt_img [16];

   initial begin
      nohalt_img = '{8'h4A, 8'h91, 8'hD3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      bus2.start = 1'b0; bus2.stall = 1'b0; bus2.branch_en = 1'b0; bus2.branch_target = '0;
      reset = 1'b1;
      #12;
      checkFetch("reset", 8'h00, 4'd0, 1'b0);
      checkOutput("reset halted", 32'(bus.halted), 32'd0);
      reset = 1'b0;
      step();
      checkFetch("idle no start", 8'h00, 4'd0, 1'b0);

      // program run to HALT
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      checkFetch("run entry", 8'h00, 4'd0, 1'b0);
      step(); checkFetch("f0", 8'h4A, 4'd0, 1'b1);
      step(); checkFetch("f1", 8'h91, 4'd1, 1'b1);
      step(); checkFetch("f2", 8'hD3, 4'd2, 1'b1);
      step(); checkFetch("f3 halt word", 8'hFF, 4'd3, 1'b1);
      checkOutput("halt word not halted", 32'(bus.halted), 32'd0);
      step();
      checkOutput("halted", 32'(bus.halted), 32'd1);
      checkOutput("halted valid", 32'(bus.fetch_valid), 32'd0);
      checkOutput("halted instr", 32'(bus.instr), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd2);
      step();
      checkOutput("halt ignores stall/branch", 32'(bus.halted), 32'd1);

      // restart from HALT, then stall for three cycles on 91
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("restart halted drops", 32'(bus.halted), 32'd0);
      step(); checkFetch("restart f0", 8'h4A, 4'd0, 1'b1);
      step(); checkFetch("restart f1", 8'h91, 4'd1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         step(); checkFetch("stall hold", 8'h91, 4'd1, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      step(); checkFetch("post stall", 8'hD3, 4'd2, 1'b1);

      // stall on the HALT fetch: HALT word only issues after release
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
      step(); checkFetch("stall before halt", 8'hD3, 4'd2, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      step(); checkFetch("halt after stall", 8'hFF, 4'd3, 1'b1);
      step(); checkOutput("halted again", 32'(bus.halted), 32'd1);

      // async reset mid-cycle while running at pc=2
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      step(); step();
      checkFetch("pre reset", 8'h91, 4'd1, 1'b1);
      #3 reset = 1'b1;
      #1;
      checkFetch("async reset", 8'h00, 4'd0, 1'b0);
      #1 reset = 1'b0;
      step(); step();
      checkFetch("idle after reset", 8'h00, 4'd0, 1'b0);
      checkOutput("idle after reset halted", 32'(bus.halted), 32'd0);

      // branch request while stalled on 4A
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      step(); checkFetch("pre branch", 8'h4A, 4'd0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd2);
      step();
`ifdef IFU_BRANCH_EN
      checkOutput("branch bubble valid", 32'(bus.fetch_valid), 32'd0);
      checkOutput("branch bubble instr", 32'(bus.instr), 32'd0);
`else
      checkFetch("branch ignored", 8'h4A, 4'd0, 1'b1);
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
      step();
`ifdef IFU_BRANCH_EN
      checkFetch("branch target", 8'hD3, 4'd2, 1'b1);
`else
      checkFetch("no branch next", 8'h91, 4'd1, 1'b1);
`endif

      // HALT-free image: PC wraps 15 -> 0 with fetch_valid held high
      bus2.start = 1'b1;
      step();
      bus2.start = 1'b0;
      for (int i = 0; i < 18; i++) begin
         step();
         checkOutput("wrap pc_out", 32'(bus2.pc_out), 32'(i % 16));
         checkOutput("wrap instr", 32'(bus2.instr), 32'(nohalt_img[i % 16]));
         checkOutput("wrap valid", 32'(bus2.fetch_valid), 32'd1);
      end
      checkOutput("wrap not halted", 32'(bus2.halted), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
